qa_driver_dsm_write_sched: RTL and testbench

QA_DRIVER_DSM_WRITE_SCHED -- requirements
Module: qa_driver_dsm_write_sched

---
 rtl/qa_driver_dsm_write_sched_if.sv | 36 +++
 rtl/qa_driver_dsm_write_sched.sv | 123 ++++++++++++
 tb/tb_qa_driver_dsm_write_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qa_driver_dsm_write_sched_if.sv
// Bundle of requester, AFU/FIU c1 and injected-write signals around the DSM write scheduler.
// master drives the scheduler inputs; slave is the scheduler itself.
interface qa_driver_dsm_write_sched_if #(
    parameter int N_REQ = 4
);
    logic [41:0]         dsm_base;
    logic                dsm_base_valid;
    logic [N_REQ-1:0]    req_valid;
    logic [4*N_REQ-1:0]  req_line;
    logic [64*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                afu_wr_valid;
    logic                fiu_alm_full;
    logic                afu_alm_full;
    logic                inj_valid;
    logic [41:0]         inj_addr;
    logic [511:0]        inj_data;
    logic [15:0]         inj_mdata;
    logic [1:0]          wr_rsp_cnt;
    logic [3:0]          outstanding;
    logic                err_underflow;

    modport master (
        output dsm_base, dsm_base_valid, req_valid, req_line, req_data,
               afu_wr_valid, fiu_alm_full, wr_rsp_cnt,
        input  req_ready, afu_alm_full, inj_valid, inj_addr, inj_data,
               inj_mdata, outstanding, err_underflow
    );

    modport slave (
        input  dsm_base, dsm_base_valid, req_valid, req_line, req_data,
               afu_wr_valid, fiu_alm_full, wr_rsp_cnt,
        output req_ready, afu_alm_full, inj_valid, inj_addr, inj_data,
               inj_mdata, outstanding, err_underflow
    );
endinterface

// File: rtl/qa_driver_dsm_write_sched.sv
// Injects driver DSM writes into idle c1 slots, round-robin across requesters,
// tracks writes in flight and throttles the AFU when driver requests starve.
module qa_driver_dsm_write_sched #(
    parameter int          N_REQ           = 4,
    parameter int          STARVE_LIMIT    = 16,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [15:0] WRITE_TAG       = 16'h0000
) (
    input logic clk,
    input logic reset_n,
    qa_driver_dsm_write_sched_if.slave bus
);
    localparam int         PW         = $clog2(N_REQ);
    localparam logic [3:0] MAX_OUT    = 4'(MAX_OUTSTANDING);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic [PW-1:0] rr_ptr;
    logic [3:0]    outstanding;
    logic [7:0]    starve_cnt;
    logic          throttle;
    logic          err_underflow;

    logic          room;
    logic          can_inj;
    logic          any_req;
    logic          grant;
    logic          blocked;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] rr_nxt;
    logic [3:0]    sel_line;
    logic [63:0]   sel_data;
    logic [4:0]    out_sum;
    logic [4:0]    rsp_ext;
    logic          underflow;
    logic [3:0]    out_nxt;
    logic [7:0]    starve_nxt;
    logic          throttle_nxt;

    assign room    = outstanding < MAX_OUT;
    // Outputs are gated with reset_n so nothing is injected while reset is held.
    assign can_inj = reset_n & bus.dsm_base_valid & ~bus.fiu_alm_full & ~bus.afu_wr_valid & room;
    assign grant   = can_inj & any_req;
    assign blocked = any_req & bus.dsm_base_valid & ~bus.fiu_alm_full & room & bus.afu_wr_valid;

    // Two passes: indices at/after rr_ptr first, then wrap to those below it.
    always_comb begin
        any_req = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_req && bus.req_valid[i] && i >= int'(rr_ptr)) begin
                any_req = 1'b1;
                gnt_idx = PW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_req && bus.req_valid[i] && i < int'(rr_ptr)) begin
                any_req = 1'b1;
                gnt_idx = PW'(i);
            end
        end
    end

    always_comb begin
        sel_line = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_line = bus.req_line[i*4 +: 4];
                sel_data = bus.req_data[i*64 +: 64];
            end
        end
    end

    assign rr_nxt = (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;

    assign out_sum   = {1'b0, outstanding} + {4'b0, grant};
    assign rsp_ext   = {3'b0, bus.wr_rsp_cnt};
    assign underflow = rsp_ext > out_sum;
    assign out_nxt   = underflow ? 4'd0 : 4'(out_sum - rsp_ext);

    always_comb begin
        starve_nxt   = starve_cnt;
        throttle_nxt = throttle;
        if (!bus.dsm_base_valid || grant) begin
            starve_nxt   = '0;
            throttle_nxt = 1'b0;
        end else begin
            if (blocked && starve_cnt < STARVE_MAX) begin
                starve_nxt = starve_cnt + 8'd1;
            end
            if (starve_nxt == STARVE_MAX) begin
                throttle_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr        <= '0;
            outstanding   <= '0;
            starve_cnt    <= '0;
            throttle      <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (grant) begin
                rr_ptr <= rr_nxt;
            end
            outstanding   <= out_nxt;
            starve_cnt    <= starve_nxt;
            throttle      <= throttle_nxt;
            err_underflow <= err_underflow | underflow;
        end
    end

    assign bus.inj_valid     = grant;
    assign bus.req_ready     = grant ? (N_REQ'(1) << gnt_idx) : '0;
    assign bus.inj_addr      = bus.dsm_base + {38'b0, sel_line};
    assign bus.inj_data      = {447'b0, 1'b1, sel_data};
    assign bus.inj_mdata     = WRITE_TAG;
    assign bus.afu_alm_full  = bus.fiu_alm_full | (throttle & reset_n);
    assign bus.outstanding   = outstanding;
    assign bus.err_underflow = err_underflow;
endmodule

// File: tb/tb_qa_driver_dsm_write_sched.sv
// Directed bench for the DSM write scheduler: reset-relative vector table plus
// hand sequences for round-robin, starvation throttle, credit limit and reset.
module tb_qa_driver_dsm_write_sched;
    localparam logic [15:0] TAG = 16'hBEEF;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    qa_driver_dsm_write_sched_if #(.N_REQ(4)) bus ();

    qa_driver_dsm_write_sched #(
        .N_REQ(4), .STARVE_LIMIT(16), .MAX_OUTSTANDING(8), .WRITE_TAG(TAG)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        logic        bv;
        logic        fiu;
        logic        afu;
        logic [3:0]  req;
        logic [1:0]  rsp;
        logic        e_inj;
        logic [3:0]  e_rdy;
        logic        e_alm;
        logic [41:0] e_addr;
        logic [63:0] e_data;
        logic [3:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n            = 1'b0;
        bus.req_valid      = '0;
        bus.afu_wr_valid   = 1'b0;
        bus.fiu_alm_full   = 1'b0;
        bus.wr_rsp_cnt     = '0;
        bus.dsm_base_valid = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    int grants;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    logic [3:0] one_hot;

    initial begin
        reset_n            = 1'b0;
        bus.dsm_base       = 42'h1000;
        bus.dsm_base_valid = 1'b1;
        bus.req_valid      = '0;
        bus.req_line       = {4'd6, 4'd5, 4'd4, 4'd3};
        bus.req_data       = {64'hA003, 64'hA002, 64'hA001, 64'hA000};
        bus.afu_wr_valid   = 1'b0;
        bus.fiu_alm_full   = 1'b0;
        bus.wr_rsp_cnt     = '0;
        @(negedge clk);

        //            bv fiu afu req     rsp inj rdy     alm addr      data      out err
        vecs[0]  = '{1, 0, 0, 4'b0101, 0, 1, 4'b0001, 0, 42'h1003, 64'hA000, 1, 0};
        vecs[1]  = '{1, 0, 0, 4'b1100, 0, 1, 4'b0100, 0, 42'h1005, 64'hA002, 1, 0};
        vecs[2]  = '{1, 0, 0, 4'b1000, 0, 1, 4'b1000, 0, 42'h1006, 64'hA003, 1, 0};
        vecs[3]  = '{1, 0, 1, 4'b1111, 0, 0, 4'b0000, 0, 42'h0,    64'h0,    0, 0};
        vecs[4]  = '{1, 1, 0, 4'b0010, 0, 0, 4'b0000, 1, 42'h0,    64'h0,    0, 0};
        vecs[5]  = '{0, 0, 0, 4'b1111, 0, 0, 4'b0000, 0, 42'h0,    64'h0,    0, 0};
        vecs[6]  = '{1, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 42'h0,    64'h0,    0, 0};
        vecs[7]  = '{1, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 42'h0,    64'h0,    0, 1};
        vecs[8]  = '{1, 0, 0, 4'b0010, 1, 1, 4'b0010, 0, 42'h1004, 64'hA001, 0, 0};
        vecs[9]  = '{1, 0, 0, 4'b0010, 2, 1, 4'b0010, 0, 42'h1004, 64'hA001, 0, 1};
        vecs[10] = '{1, 1, 1, 4'b0001, 0, 0, 4'b0000, 1, 42'h0,    64'h0,    0, 0};

        // Reset state
        do_reset();
        chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
        chk("rst_err", 64'(bus.err_underflow), 64'd0);
        chk("rst_alm", 64'(bus.afu_alm_full), 64'd0);

        for (int v = 0; v < 11; v++) begin
            do_reset();
            bus.dsm_base_valid = vecs[v].bv;
            bus.fiu_alm_full   = vecs[v].fiu;
            bus.afu_wr_valid   = vecs[v].afu;
            bus.req_valid      = vecs[v].req;
            bus.wr_rsp_cnt     = vecs[v].rsp;
            #1;
            chk($sformatf("v%0d_inj_valid", v), 64'(bus.inj_valid), 64'(vecs[v].e_inj));
            chk($sformatf("v%0d_req_ready", v), 64'(bus.req_ready), 64'(vecs[v].e_rdy));
            chk($sformatf("v%0d_afu_alm", v), 64'(bus.afu_alm_full), 64'(vecs[v].e_alm));
            if (vecs[v].e_inj) begin
                chk($sformatf("v%0d_addr", v), 64'(bus.inj_addr), 64'(vecs[v].e_addr));
                chk($sformatf("v%0d_data_lo", v), bus.inj_data[63:0], vecs[v].e_data);
                chk($sformatf("v%0d_data_b64", v), 64'(bus.inj_data[64]), 64'd1);
                chk($sformatf("v%0d_data_hi0", v), 64'(|bus.inj_data[511:65]), 64'd0);
                chk($sformatf("v%0d_mdata", v), 64'(bus.inj_mdata), 64'(TAG));
            end
            tick();
            bus.req_valid  = '0;
            bus.wr_rsp_cnt = '0;
            chk($sformatf("v%0d_outstanding", v), 64'(bus.outstanding), 64'(vecs[v].e_out));
            chk($sformatf("v%0d_err", v), 64'(bus.err_underflow), 64'(vecs[v].e_err));
        end

        // Round-robin with one response per cycle
        do_reset();
        bus.req_valid  = 4'b1111;
        bus.wr_rsp_cnt = 2'd1;
        for (int c = 0; c < 5; c++) begin
            #1;
            one_hot = 4'b0001 << exp_seq[c];
            chk($sformatf("rr_grant%0d", c), 64'(bus.req_ready), 64'(one_hot));
            tick();
            chk($sformatf("rr_out_le1_%0d", c), 64'(bus.outstanding <= 4'd1), 64'd1);
            chk($sformatf("rr_err%0d", c), 64'(bus.err_underflow), 64'd0);
        end

        // Specific address/data composition
        do_reset();
        bus.dsm_base  = 42'h1000;
        bus.req_line  = {4'd6, 4'd5, 4'd4, 4'd3};
        bus.req_data  = {64'hA003, 64'hDEAD, 64'hA001, 64'hA000};
        bus.req_valid = 4'b0100;
        #1;
        chk("ex_addr", 64'(bus.inj_addr), 64'h1005);
        chk("ex_data_lo", bus.inj_data[63:0], 64'hDEAD);
        chk("ex_data_b64", 64'(bus.inj_data[64]), 64'd1);
        chk("ex_mdata", 64'(bus.inj_mdata), 64'(TAG));
        chk("ex_ready", 64'(bus.req_ready), 64'b0100);
        tick();
        bus.req_valid = '0;
        bus.req_data  = {64'hA003, 64'hA002, 64'hA001, 64'hA000};

        // Starvation throttle
        do_reset();
        bus.req_valid    = 4'b0001;
        bus.afu_wr_valid = 1'b1;
        for (int c = 0; c < 15; c++) tick();
        chk("starve_alm_15", 64'(bus.afu_alm_full), 64'd0);
        chk("starve_inj_blocked", 64'(bus.inj_valid), 64'd0);
        tick();
        chk("starve_alm_16", 64'(bus.afu_alm_full), 64'd1);
        tick();
        chk("starve_alm_hold", 64'(bus.afu_alm_full), 64'd1);
        bus.afu_wr_valid = 1'b0;
        #1;
        chk("starve_grant", 64'(bus.req_ready), 64'b0001);
        tick();
        bus.req_valid = '0;
        #1;
        chk("starve_alm_clear", 64'(bus.afu_alm_full), 64'd0);
        chk("starve_out", 64'(bus.outstanding), 64'd1);

        // Outstanding credit limit
        do_reset();
        bus.req_valid = 4'b1111;
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.inj_valid) grants++;
            tick();
        end
        chk("limit_grants", 64'(grants), 64'd8);
        chk("limit_out", 64'(bus.outstanding), 64'd8);
        #1;
        chk("limit_inj_off", 64'(bus.inj_valid), 64'd0);
        bus.wr_rsp_cnt = 2'd1;
        tick();
        bus.wr_rsp_cnt = 2'd0;
        grants = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.inj_valid) grants++;
            tick();
        end
        chk("limit_one_more", 64'(grants), 64'd1);
        chk("limit_out_again", 64'(bus.outstanding), 64'd8);
        bus.req_valid = '0;

        // Sticky underflow
        do_reset();
        bus.wr_rsp_cnt = 2'd2;
        tick();
        bus.wr_rsp_cnt = 2'd0;
        chk("uf_out", 64'(bus.outstanding), 64'd0);
        chk("uf_err", 64'(bus.err_underflow), 64'd1);
        for (int c = 0; c < 3; c++) tick();
        chk("uf_sticky", 64'(bus.err_underflow), 64'd1);

        // Reset with outstanding=5 and throttle set
        do_reset();
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) tick();
        bus.afu_wr_valid = 1'b1;
        for (int c = 0; c < 16; c++) tick();
        chk("pre_rst_out", 64'(bus.outstanding), 64'd5);
        chk("pre_rst_alm", 64'(bus.afu_alm_full), 64'd1);
        reset_n          = 1'b0;
        bus.afu_wr_valid = 1'b0;
        #1;
        chk("in_rst_inj", 64'(bus.inj_valid), 64'd0);
        chk("in_rst_ready", 64'(bus.req_ready), 64'd0);
        chk("in_rst_alm", 64'(bus.afu_alm_full), 64'd0);
        tick();
        chk("post_rst_out", 64'(bus.outstanding), 64'd0);
        chk("post_rst_err", 64'(bus.err_underflow), 64'd0);
        bus.fiu_alm_full = 1'b1;
        #1;
        chk("post_rst_alm_fiu", 64'(bus.afu_alm_full), 64'd1);
        bus.fiu_alm_full = 1'b0;
        reset_n          = 1'b1;
        bus.req_valid    = 4'b1111;
        #1;
        chk("post_rst_alm_clr", 64'(bus.afu_alm_full), 64'd0);
        chk("post_rst_rr0", 64'(bus.req_ready), 64'b0001);
        tick();
        bus.req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
